// File: rtl/inst_fetch_queue.sv
// Two-in / two-out circular instruction buffer between fetch and pre-decode.
// A flush empties the queue; the storage array itself is never reset.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int INST_W = `INST_WIDTH,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        enq_valid,
  input  logic [INST_W-1:0] enq_inst_0,
  input  logic [INST_W-1:0] enq_inst_1,
  input  logic [PC_W-1:0]   enq_pc_0,
  input  logic [PC_W-1:0]   enq_pc_1,
  output logic              enq_ready,
  input  logic              deq_ready,
  output logic [INST_W-1:0] out_inst_0,
  output logic [INST_W-1:0] out_inst_1,
  output logic [PC_W-1:0]   out_pc_0,
  output logic [PC_W-1:0]   out_pc_1,
  output logic [1:0]        out_inst_valid,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];

  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [PTR_W-1:0] head_idx_s, head1_idx_s, tail_idx_s, tail1_idx_s;
  logic [1:0]       enq_n_s, deq_n_s;
  logic             enq_fire_s, v0_s, v1_s;
  logic [INST_W-1:0] wr0_inst_s;
  logic [PC_W-1:0]   wr0_pc_s;

  assign head_idx_s  = head_q[PTR_W-1:0];
  assign head1_idx_s = head_idx_s + PTR_W'(1);
  assign tail_idx_s  = tail_q[PTR_W-1:0];
  assign tail1_idx_s = tail_idx_s + PTR_W'(1);

  // Handshake, enqueue count and slot compaction; flush blocks both directions.
  always_comb begin
    enq_fire_s = ((DEPTH_V - count_q) >= (PTR_W+1)'(2)) && !flush;
    v0_s       = deq_ready && !flush && (count_q >= (PTR_W+1)'(1));
    v1_s       = deq_ready && !flush && (count_q >= (PTR_W+1)'(2));
    deq_n_s    = {1'b0, v0_s} + {1'b0, v1_s};
    case (enq_valid)
      2'b00:   enq_n_s = 2'd0;
      2'b01:   enq_n_s = 2'd1;
      2'b10:   enq_n_s = 2'd1;
      2'b11:   enq_n_s = 2'd2;
      default: enq_n_s = 2'd0;
    endcase
    if (enq_valid == 2'b10) begin
      wr0_inst_s = enq_inst_1;
      wr0_pc_s   = enq_pc_1;
    end else begin
      wr0_inst_s = enq_inst_0;
      wr0_pc_s   = enq_pc_0;
    end
  end

  // Pointer and occupancy update; flush restarts the queue at index zero.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + (PTR_W+1)'(deq_n_s);
      if (enq_fire_s) begin
        tail_d  = tail_q + (PTR_W+1)'(enq_n_s);
        count_d = count_q + (PTR_W+1)'(enq_n_s) - (PTR_W+1)'(deq_n_s);
      end else begin
        tail_d  = tail_q;
        count_d = count_q - (PTR_W+1)'(deq_n_s);
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write; slot1 goes to tail+1 only for a full two-wide batch.
  always_ff @(posedge clk) begin
    if (enq_fire_s && (enq_n_s != 2'd0)) begin
      inst_mem_q[tail_idx_s] <= wr0_inst_s;
      pc_mem_q[tail_idx_s]   <= wr0_pc_s;
    end
    if (enq_fire_s && (enq_valid == 2'b11)) begin
      inst_mem_q[tail1_idx_s] <= enq_inst_1;
      pc_mem_q[tail1_idx_s]   <= enq_pc_1;
    end
  end

  // Presented slots read zero whenever they are not valid.
  always_comb begin
    enq_ready      = enq_fire_s;
    out_inst_valid = {v1_s, v0_s};
    count          = count_q;
    if (v0_s) begin
      out_inst_0 = inst_mem_q[head_idx_s];
      out_pc_0   = pc_mem_q[head_idx_s];
    end else begin
      out_inst_0 = '0;
      out_pc_0   = '0;
    end
    if (v1_s) begin
      out_inst_1 = inst_mem_q[head1_idx_s];
      out_pc_1   = pc_mem_q[head1_idx_s];
    end else begin
      out_inst_1 = '0;
      out_pc_1   = '0;
    end
  end

  inst_fetch_queue_chk #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .head      (head_q),
    .tail      (tail_q),
    .cnt       (count_q),
    .out_valid (out_inst_valid)
  );

endmodule

// Structural invariants of the queue pointers and presented slots.
module inst_fetch_queue_chk #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  input logic [PTR_W:0] head,
  input logic [PTR_W:0] tail,
  input logic [PTR_W:0] cnt,
  input logic [1:0]     out_valid
);
  a_count_ptr: assert property (@(posedge clk) disable iff (!rst_n)
    cnt == (tail - head));
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= (PTR_W+1)'(DEPTH));
  a_valid_order: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid[1] |-> out_valid[0]);
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, ordering, full, wrap, flush.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  enq_valid = 2'b00;
  logic [31:0] enq_inst_0 = 32'h0, enq_inst_1 = 32'h0;
  logic [31:0] enq_pc_0 = 32'h0, enq_pc_1 = 32'h0;
  logic        enq_ready;
  logic        deq_ready = 1'b1;
  logic [31:0] out_inst_0, out_inst_1, out_pc_0, out_pc_1;
  logic [1:0]  out_inst_valid;
  logic [PTR_W:0] count;

  int compared = 0;
  int mismatched = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid),
    .enq_inst_0(enq_inst_0), .enq_inst_1(enq_inst_1),
    .enq_pc_0(enq_pc_0), .enq_pc_1(enq_pc_1), .enq_ready(enq_ready),
    .deq_ready(deq_ready), .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
    .out_inst_valid(out_inst_valid), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs (just after a rising edge) and let outputs settle.
  task automatic drive(input logic f, input logic [1:0] ev,
                       input logic [31:0] p0, input logic [31:0] p1, input logic dr);
    flush = f; enq_valid = ev; deq_ready = dr;
    enq_pc_0 = p0; enq_pc_1 = p1;
    enq_inst_0 = inst_of(p0); enq_inst_1 = inst_of(p1);
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held: outputs idle even with deq_ready high.
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_inst_valid, 0);
    chk("rst_inst0", out_inst_0, 0);
    chk("rst_pc1", out_pc_1, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("idle_valid", out_inst_valid, 0);
    chk("idle_count", count, 0);

    // Two-wide enqueue while the back end stalls, then drain it.
    drive(1'b0, 2'b11, 32'h1000, 32'h1004, 1'b0);
    enq_inst_0 = 32'h00100093; enq_inst_1 = 32'h00200113; #1;
    tick;
    chk("b1_count2", count, 2);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    chk("b1_stall_valid", out_inst_valid, 0);
    deq_ready = 1'b1; #1;
    chk("b1_valid", out_inst_valid, 2'b11);
    chk("b1_inst0", out_inst_0, 32'h00100093);
    chk("b1_inst1", out_inst_1, 32'h00200113);
    chk("b1_pc0", out_pc_0, 32'h1000);
    chk("b1_pc1", out_pc_1, 32'h1004);
    tick;
    chk("b1_count0", count, 0);

    // Slot1-only batch is compacted into one entry; no same-cycle bypass.
    drive(1'b0, 2'b10, 32'hDEAD_0000, 32'h2004, 1'b1);
    enq_inst_1 = 32'h00308193; #1;
    chk("b2_no_bypass", out_inst_valid, 0);
    tick;
    chk("b2_count1", count, 1);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("b2_valid", out_inst_valid, 2'b01);
    chk("b2_inst0", out_inst_0, 32'h00308193);
    chk("b2_pc0", out_pc_0, 32'h2004);
    chk("b2_inst1_zero", out_inst_1, 0);
    tick;
    chk("b2_count0", count, 0);

    // Fill to DEPTH (head sits at index 3, so the drain straddles 7/0).
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 2'b11, 32'h3000 + 32'(8*b), 32'h3004 + 32'(8*b), 1'b0);
      chk("fill_ready", enq_ready, 1);
      tick;
      chk("fill_count", count, 64'(2*(b+1)));
    end
    drive(1'b0, 2'b11, 32'h4000, 32'h4004, 1'b0);
    chk("full_ready", enq_ready, 0);
    tick;
    chk("full_count", count, 8);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk("drain_valid", out_inst_valid, 2'b11);
      chk("drain_pc0", out_pc_0, 32'h3000 + 32'(8*k));
      chk("drain_pc1", out_pc_1, 32'h3004 + 32'(8*k));
      chk("drain_inst1", out_inst_1, inst_of(32'h3004 + 32'(8*k)));
      tick;
    end
    chk("drain_count", count, 0);

    // Steady state: two in, two out per cycle at constant occupancy.
    drive(1'b0, 2'b11, 32'h5000, 32'h5004, 1'b0);
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b11, 32'h5008 + 32'(8*i), 32'h500C + 32'(8*i), 1'b1);
      chk("ss_valid", out_inst_valid, 2'b11);
      chk("ss_pc0", out_pc_0, 32'h5000 + 32'(8*i));
      chk("ss_pc1", out_pc_1, 32'h5004 + 32'(8*i));
      chk("ss_inst0", out_inst_0, inst_of(32'h5000 + 32'(8*i)));
      tick;
      chk("ss_count", count, 2);
    end

    // Build count=5, then flush with a batch and deq_ready present.
    drive(1'b0, 2'b11, 32'h6000, 32'h6004, 1'b0);
    tick;
    drive(1'b0, 2'b01, 32'h6008, 32'h0, 1'b0);
    tick;
    chk("pre_flush_count", count, 5);
    chk("pre_flush_ready", enq_ready, 1);
    drive(1'b1, 2'b11, 32'h7000, 32'h7004, 1'b1);
    chk("flush_valid", out_inst_valid, 0);
    chk("flush_ready", enq_ready, 0);
    chk("flush_pc0", out_pc_0, 0);
    tick;
    chk("post_flush_count", count, 0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("post_flush_empty", out_inst_valid, 0);
    drive(1'b0, 2'b01, 32'h8000, 32'h0, 1'b1);
    tick;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    deq_ready = 1'b1; #1;
    chk("post_flush_valid", out_inst_valid, 2'b01);
    chk("post_flush_pc0", out_pc_0, 32'h8000);

    // Occupancy DEPTH-1 refuses a batch; queue stays at 7.
    deq_ready = 1'b0; #1;
    for (int b = 0; b < 3; b++) begin
      drive(1'b0, 2'b11, 32'h9000 + 32'(8*b), 32'h9004 + 32'(8*b), 1'b0);
      tick;
    end
    chk("seven_count", count, 7);
    drive(1'b0, 2'b01, 32'hA000, 32'h0, 1'b0);
    chk("seven_ready", enq_ready, 0);
    tick;
    chk("seven_hold", count, 7);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("seven_pc0", out_pc_0, 32'h8000);
    chk("seven_pc1", out_pc_1, 32'h9000);

    // Asynchronous reset mid-burst clears occupancy without a clock edge.
    #2 rst_n = 1'b0; #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_inst_valid, 0);
    chk("async_rst_ready", enq_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Circular instruction buffer between the instruction-fetch unit and the pre-decode stage. Accepts up to 2 instructions (with PCs) per cycle from fetch. Presents up to 2 in-order instructions per cycle on the pre-decode inputs (inst_0/inst_1/valid[1:0]). Decouples fetch bursts from back-end stalls and discards all contents on a pipeline flush.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
PTR_W, $clog2(DEPTH), index width; pointers carry one extra wrap bit
INST_W, `INST_WIDTH (32), instruction width
PC_W, 32, program-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous flush (branch mispredict / exception redirect)
enq_valid  in  2  per-slot valid from fetch; bit0 = slot0 (older)
enq_inst_0  in  INST_W  fetch slot0 instruction
enq_inst_1  in  INST_W  fetch slot1 instruction
enq_pc_0  in  PC_W  PC of slot0
enq_pc_1  in  PC_W  PC of slot1
enq_ready  out  1  queue can accept a full 2-wide batch this cycle
deq_ready  in  1  downstream (pre-decode/rename) accepts instructions this cycle
out_inst_0  out  INST_W  oldest entry (to pre-decode in_inst_0)
out_inst_1  out  INST_W  second-oldest entry (to pre-decode in_inst_1)
out_pc_0  out  PC_W  PC of out_inst_0
out_pc_1  out  PC_W  PC of out_inst_1
out_inst_valid  out  2  per-slot valid (to pre-decode in_inst_valid)
count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage array (inst, pc) x DEPTH; head and tail pointers (PTR_W+1 bits, MSB = wrap); count register. Storage is not reset.
- Reset (async, rst_n=0): head=tail=0, count=0. Outputs therefore read: enq_ready=1, out_inst_valid=2'b00, out_inst_*=0, out_pc_*=0. Reset mid-burst drops all entries immediately.
- enq_ready = (DEPTH - count) >= 2, from registered count only. No combinational path from enq_valid or deq_ready.
- Enqueue happens when enq_ready=1 and flush=0. Number enqueued: enq_n = popcount(enq_valid).
  - 2'b01: slot0 written at tail.
  - 2'b11: slot0 at tail, slot1 at tail+1.
  - 2'b10: slot1 is compacted and written at tail.
  - tail advances by enq_n.
- enq_valid!=0 while enq_ready=0: batch is ignored, and fetch must hold it. Not an error.
- Dequeue outputs are combinational from registered state plus deq_ready:
  - out_inst_valid[0] = deq_ready & (count >= 1)
  - out_inst_valid[1] = deq_ready & (count >= 2)
  - out_inst_0/out_pc_0 = entry[head] when valid[0], else 0.
  - out_inst_1/out_pc_1 = entry[head+1] when valid[1], else 0.
  - valid[1]=1 implies valid[0]=1.
- Dequeue is committed at the clock edge: head advances by deq_n = popcount(out_inst_valid) when flush=0. Pre-decode has no back-pressure, so a presented valid is a consumed valid.
- Latency: no bypass. An entry written in cycle N is first presentable in cycle N+1.
- Simultaneous enq/deq: count_next = count + enq_n - deq_n. Overflow is impossible by enq_ready; underflow is impossible by valid gating.
- Full (count=DEPTH) or count=DEPTH-1: enq_ready=0; dequeue proceeds normally.
- Empty: out_inst_valid=0 regardless of deq_ready.
- Wrap-around: indices use pointer[PTR_W-1:0]. An entry pair may straddle DEPTH-1 -> 0, with head+1 wrapping modulo DEPTH.
- Flush (priority over enq and deq):
  - Combinationally forces out_inst_valid=2'b00 and enq_ready=0 in the flush cycle.
  - At the edge: head=tail=0, count=0; the same-cycle enq batch is discarded.
  - Flush with rst_n low: reset dominates.
- Invariant: count == tail - head (mod 2*DEPTH), checked by assertion.

Test Plan:
- Reset then idle → enq_ready=1, count=0, out_inst_valid=00 with deq_ready=1, outputs zero.
- deq_ready=0. Enqueue 11 with inst 0x00100093/0x00200113, PCs 0x1000/0x1004. Then deq_ready=1 next cycle → out_inst_valid=11, out_inst_0=0x00100093, out_pc_1=0x1004. Count goes 2 then 0.
- enq_valid=2'b10, inst_1=0x00308193, pc_1=0x2004, into empty queue → next cycle out_inst_valid=01, out_inst_0=0x00308193, out_pc_0=0x2004.
- DEPTH=8, deq_ready=0, four 11 batches → count=8, enq_ready=0. A fifth batch is ignored. Dequeue pattern is PC-ordered with no loss or duplication.
- Steady state: enqueue 11 and dequeue 11 for 10 cycles with incrementing PCs → count stays constant. The pointer wraps with an entry pair straddling index 7/0, and PC order is preserved.
- count=5, assert flush with enq_valid=11 and deq_ready=1 → that cycle out_inst_valid=00, enq_ready=0. Next cycle count=0, and old and flush-cycle instructions never appear.
